sbus_arbiter: RTL and testbench

//  Shares one physical memory port between the core's instruction and data masters (post-MMU, physical addresses).

---
 rtl/sbus_arbiter_pkg.sv | 18 +
 rtl/sbus_arb_grant.sv | 49 ++++
 rtl/sbus_arbiter.sv | 149 ++++++++++++++
 tb/tb_sbus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sbus_arbiter_pkg
// Shared types and constants for the system-bus arbiter.
//   arb_state            : arbiter FSM state encoding
//   ARB_MAX_WAIT_DEFAULT : default number of lost arbitrations an instruction
//                          request may suffer before it is forced to win
// ---------------------------------------------------------------------------
package sbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state;

    localparam int ARB_MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/sbus_arb_grant.sv
// ---------------------------------------------------------------------------
// sbus_arb_grant
// Winner selection for the system-bus arbiter plus the instruction-side
// starvation counter.
//   clk, rst  : clock, synchronous active-high reset
//   idle      : arbiter is in IDLE and may grant this cycle
//   i_req     : instruction master request
//   d_req     : data master request
//   grant_i   : instruction side wins this cycle (combinational)
//   grant_d   : data side wins this cycle (combinational)
//   wait_cnt  : number of consecutive conflicts lost by the instruction side
// ---------------------------------------------------------------------------
module sbus_arb_grant
    import sbus_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       i_req,
    input  logic       d_req,
    output logic       grant_i,
    output logic       grant_d,
    output logic [7:0] wait_cnt
);

    logic starved;

    // Data wins by default; a starved instruction side overrides it.
    always_comb begin
        starved = (wait_cnt == 8'(MAX_WAIT));
        grant_d = idle && d_req && !(i_req && starved);
        grant_i = idle && i_req && !grant_d;
    end

    // Counts only conflicts the instruction side lost; since idle gates both
    // grants, nothing changes while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (grant_i) begin
            wait_cnt <= 8'd0;
        end else if (grant_d && i_req && (wait_cnt < 8'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sbus_arbiter.sv
// ---------------------------------------------------------------------------
// sbus_arbiter
// Shares one memory port between the instruction and data masters, one whole
// transaction at a time. Data has priority; the instruction side is forced to
// win after MAX_WAIT lost conflicts.
//
// Optional feature macro: SBUS_ARB_STATS_EN
//   defined     : stat_* are 32-bit wrapping grant/conflict counters
//   not defined : stat_* are tied to 0
//
// Handshake: a master raises x_req with x_addr/x_we/x_wdata stable and holds
// them until the single-cycle x_ready pulse. Downstream, s_req and s_* are
// registered and held constant until the single-cycle s_ready pulse, which is
// passed straight through to the owning master as x_ready in the same cycle.
//
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   i_req/i_addr/i_we/i_wdata        : instruction master request
//   i_rdata/i_ready                  : instruction master response
//   d_req/d_addr/d_we/d_wdata        : data master request
//   d_rdata/d_ready                  : data master response
//   s_req/s_addr/s_we/s_wdata        : downstream request (registered)
//   s_rdata/s_ready                  : downstream response
//   stat_i_grant/stat_d_grant        : grant counters
//   stat_conflict                    : IDLE cycles with both requests set
//   dbg_state                        : current FSM state
//   dbg_wait_cnt                     : starvation counter
// ---------------------------------------------------------------------------
module sbus_arbiter
    import sbus_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic [3:0]  s_we,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [31:0] stat_i_grant,
    output logic [31:0] stat_d_grant,
    output logic [31:0] stat_conflict,
    output logic [1:0]  dbg_state,
    output logic [7:0]  dbg_wait_cnt
);

    arb_state state;
    logic     idle;
    logic     grant_i;
    logic     grant_d;

    assign idle = (state == ARB_IDLE);

    sbus_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .idle     (idle),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_i  (grant_i),
        .grant_d  (grant_d),
        .wait_cnt (dbg_wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            s_req   <= 1'b0;
            s_addr  <= 32'd0;
            s_we    <= 4'd0;
            s_wdata <= 32'd0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state   <= ARB_BUSY_D;
                        s_req   <= 1'b1;
                        s_addr  <= d_addr;
                        s_we    <= d_we;
                        s_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state   <= ARB_BUSY_I;
                        s_req   <= 1'b1;
                        s_addr  <= i_addr;
                        s_we    <= i_we;
                        s_wdata <= i_wdata;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    // Returning to IDLE here forces one idle cycle between
                    // back-to-back downstream transactions.
                    if (s_ready) begin
                        state <= ARB_IDLE;
                        s_req <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    s_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion is steered by state, so s_ready seen in IDLE goes nowhere.
    always_comb begin
        i_ready = (state == ARB_BUSY_I) && s_ready;
        d_ready = (state == ARB_BUSY_D) && s_ready;
        i_rdata = (state == ARB_BUSY_I) ? s_rdata : 32'd0;
        d_rdata = (state == ARB_BUSY_D) ? s_rdata : 32'd0;
    end

    assign dbg_state = state;

`ifdef SBUS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_grant  <= 32'd0;
            stat_d_grant  <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (grant_i) stat_i_grant <= stat_i_grant + 32'd1;
            if (grant_d) stat_d_grant <= stat_d_grant + 32'd1;
            if (idle && i_req && d_req) stat_conflict <= stat_conflict + 32'd1;
        end
    end
`else
    assign stat_i_grant  = 32'd0;
    assign stat_d_grant  = 32'd0;
    assign stat_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_sbus_arbiter.sv
module tb_sbus_arbiter;
    import sbus_arbiter_pkg::*;

    localparam int MW = 2;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [3:0]  i_we;
    logic [31:0] i_wdata;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        s_req;
    logic [31:0] s_addr;
    logic [3:0]  s_we;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic [31:0] stat_i_grant;
    logic [31:0] stat_d_grant;
    logic [31:0] stat_conflict;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_wait_cnt;

    sbus_arbiter #(.MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_we          (i_we),
        .i_wdata       (i_wdata),
        .i_rdata       (i_rdata),
        .i_ready       (i_ready),
        .d_req         (d_req),
        .d_addr        (d_addr),
        .d_we          (d_we),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_ready       (d_ready),
        .s_req         (s_req),
        .s_addr        (s_addr),
        .s_we          (s_we),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ready       (s_ready),
        .stat_i_grant  (stat_i_grant),
        .stat_d_grant  (stat_d_grant),
        .stat_conflict (stat_conflict),
        .dbg_state     (dbg_state),
        .dbg_wait_cnt  (dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = instruction, 2 = data
    int          m_owner = 0;
    int          m_wait  = 0;
    logic        m_sreq  = 1'b0;
    logic [31:0] m_addr  = 32'd0;
    logic [3:0]  m_we    = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_si    = 32'd0;
    logic [31:0] m_sd    = 32'd0;
    logic [31:0] m_sc    = 32'd0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0; m_wait = 0; m_sreq = 1'b0;
            m_addr = 32'd0; m_we = 4'd0; m_wdata = 32'd0;
            m_si = 32'd0; m_sd = 32'd0; m_sc = 32'd0;
        end else if (m_owner == 0) begin
            if (i_req && d_req) m_sc = m_sc + 32'd1;
            if (d_req && !(i_req && m_wait == MW)) begin
                m_owner = 2;
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                m_sd = m_sd + 32'd1;
                if (i_req) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
                exp_q.push_back(d_addr);
            end else if (i_req) begin
                m_owner = 1;
                m_addr = i_addr; m_we = i_we; m_wdata = i_wdata;
                m_si = m_si + 32'd1;
                m_wait = 0;
                exp_q.push_back(i_addr);
            end
            m_sreq = (m_owner != 0);
        end else if (s_ready) begin
            m_owner = 0;
            m_sreq  = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic i_done = 1'b0;
    logic d_done = 1'b0;
    logic s_req_prev = 1'b0;

    always @(negedge clk) begin
        i_done = i_ready;
        d_done = d_ready;
        chk("s_req",   32'(s_req),   32'(m_sreq));
        chk("s_addr",  s_addr,       m_addr);
        chk("s_we",    32'(s_we),    32'(m_we));
        chk("s_wdata", s_wdata,      m_wdata);
        chk("i_ready", 32'(i_ready), 32'((m_owner == 1) && s_ready));
        chk("d_ready", 32'(d_ready), 32'((m_owner == 2) && s_ready));
        chk("i_rdata", i_rdata,      (m_owner == 1) ? s_rdata : 32'd0);
        chk("d_rdata", d_rdata,      (m_owner == 2) ? s_rdata : 32'd0);
        chk("state",   32'(dbg_state),    32'(m_owner));
        chk("wait",    32'(dbg_wait_cnt), 32'(m_wait));
`ifdef SBUS_ARB_STATS_EN
        chk("stat_i", stat_i_grant,  m_si);
        chk("stat_d", stat_d_grant,  m_sd);
        chk("stat_c", stat_conflict, m_sc);
`else
        chk("stat_i", stat_i_grant,  32'd0);
        chk("stat_d", stat_d_grant,  32'd0);
        chk("stat_c", stat_conflict, 32'd0);
`endif
        // Scoreboard: each new downstream transaction must match the next grant.
        if (s_req && !s_req_prev) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL txn_q: got s_addr 0x%08h expected no transaction", s_addr);
            end else begin
                chk("txn_addr", s_addr, exp_q.pop_front());
            end
        end
        s_req_prev = s_req;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; s_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait for a downstream request, report its owner, complete it after lat cycles.
    task automatic serve(input logic [31:0] rd, input int lat, output int owner);
        int n;
        n = 0;
        owner = -1;
        while (s_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) begin
            checks++; failures++;
            $display("FAIL serve_timeout: got no s_req expected s_req within 30 cycles");
            return;
        end
        owner = int'(dbg_state);
        repeat (lat) step();
        s_ready = 1'b1;
        s_rdata = rd;
        step();
        s_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int own;

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0; i_we = 4'd0; i_wdata = 32'd0;
        d_req = 1'b0; d_addr = 32'd0; d_we = 4'd0; d_wdata = 32'd0;
        s_rdata = 32'd0; s_ready = 1'b0;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_s_req", 32'(s_req), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("rst_stat_d", stat_d_grant, 32'd0);

        // 1: lone data read
        step();
        d_req = 1'b1; d_addr = 32'h0000_1000; d_we = 4'd0;
        step();
        @(negedge clk);
        chk("t1_s_req", 32'(s_req), 32'd1);
        chk("t1_s_addr", s_addr, 32'h0000_1000);
        step();
        step();
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_d_ready", 32'(d_ready), 32'd1);
        chk("t1_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t1_i_ready", 32'(i_ready), 32'd0);
        step();
        s_ready = 1'b0; d_req = 1'b0;

        // 2: collision, data first then instruction
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_2000; i_we = 4'd0;
        d_req = 1'b1; d_addr = 32'h0000_3000; d_we = 4'd0;
        step();
        @(negedge clk);
        chk("t2_first", s_addr, 32'h0000_3000);
        chk("t2_first_st", 32'(dbg_state), 32'(ARB_BUSY_D));
        chk("t2_wait1", 32'(dbg_wait_cnt), 32'd1);
        step();
        s_ready = 1'b1; s_rdata = 32'h0000_0011;
        @(negedge clk);
        chk("t2_d_ready", 32'(d_ready), 32'd1);
        step();
        s_ready = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("t2_gap", 32'(s_req), 32'd0);
        step();
        @(negedge clk);
        chk("t2_second", s_addr, 32'h0000_2000);
        chk("t2_second_st", 32'(dbg_state), 32'(ARB_BUSY_I));
        step();
        s_ready = 1'b1; s_rdata = 32'h0000_0022;
        @(negedge clk);
        chk("t2_i_ready", 32'(i_ready), 32'd1);
        chk("t2_i_rdata", i_rdata, 32'h0000_0022);
        chk("t2_d_quiet", 32'(d_ready), 32'd0);
        step();
        s_ready = 1'b0; i_req = 1'b0;
        @(negedge clk);
`ifdef SBUS_ARB_STATS_EN
        chk("t2_stat_d", stat_d_grant, 32'd1);
        chk("t2_stat_i", stat_i_grant, 32'd1);
        chk("t2_stat_c", stat_conflict, 32'd1);
`else
        chk("t2_stat_d", stat_d_grant, 32'd0);
        chk("t2_stat_i", stat_i_grant, 32'd0);
        chk("t2_stat_c", stat_conflict, 32'd0);
`endif

        // 3: starvation guard with MAX_WAIT=2
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_A000;
        d_req = 1'b1; d_addr = 32'h0000_B000;
        serve(32'h1, 1, own);
        chk("t3_grant1", 32'(own), 32'(ARB_BUSY_D));
        serve(32'h2, 0, own);
        chk("t3_grant2", 32'(own), 32'(ARB_BUSY_D));
        serve(32'h3, 2, own);
        chk("t3_grant3", 32'(own), 32'(ARB_BUSY_I));
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("t3_wait0", 32'(dbg_wait_cnt), 32'd0);

        // 4: data write, s_* held stable until s_ready
        step();
        d_req = 1'b1; d_addr = 32'h0000_5000; d_we = 4'b0011; d_wdata = 32'h1234_5678;
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_s_we", 32'(s_we), 32'h3);
            chk("t4_s_wdata", s_wdata, 32'h1234_5678);
            chk("t4_i_ready", 32'(i_ready), 32'd0);
            step();
        end
        s_ready = 1'b1; s_rdata = 32'h0;
        @(negedge clk);
        chk("t4_d_ready", 32'(d_ready), 32'd1);
        chk("t4_i_quiet", 32'(i_ready), 32'd0);
        step();
        s_ready = 1'b0; d_req = 1'b0; d_we = 4'd0;

        // 5: reset while BUSY_I, then a late s_ready
        step();
        i_req = 1'b1; i_addr = 32'h0000_4000;
        step();
        @(negedge clk);
        chk("t5_busy", 32'(dbg_state), 32'(ARB_BUSY_I));
        step();
        rst = 1'b1; i_req = 1'b0;
        step();
        rst = 1'b0; s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("t5_s_req", 32'(s_req), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("t5_i_ready", 32'(i_ready), 32'd0);
        chk("t5_d_ready", 32'(d_ready), 32'd0);
        step();
        s_ready = 1'b0;

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = $urandom; i_wdata = $urandom;
                i_we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_we = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
            end
            if (s_ready) begin
                s_ready = 1'b0;
            end else if (s_req && $urandom_range(0, 2) == 0) begin
                s_ready = 1'b1; s_rdata = $urandom;
            end else if (!s_req && $urandom_range(0, 7) == 0) begin
                s_ready = 1'b1; s_rdata = $urandom;
            end
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; s_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("end_txn_q", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
